// File: rtl/conv_pkg.sv
// Shared types and constants for the multi-channel 3x3 fp16 convolution kernel.
package conv_pkg;
    localparam int NTAPS    = 9;
    localparam int CONV_LAT = 5;

    typedef logic [15:0] fp16_t;

    localparam fp16_t FP16_ZERO = 16'h0000;
    localparam fp16_t FP16_QNAN = 16'h7E00;

    typedef struct packed {
        fp16_t [NTAPS-1:0] p;
        fp16_t             bias;
        logic              relu;
    } s1_t;

    typedef struct packed {
        fp16_t [3:0] s;
        fp16_t       p8;
        fp16_t       bias;
        logic        relu;
    } s2_t;

    typedef struct packed {
        fp16_t q0;
        fp16_t q1;
        fp16_t p8;
        fp16_t bias;
        logic  relu;
    } s3_t;

    typedef struct packed {
        fp16_t r;
        fp16_t t;
        logic  relu;
    } s4_t;

    // NaN keeps its payload; -0 and negatives clamp to +0 when enabled.
    function automatic fp16_t relu_act(input fp16_t y, input logic en);
        logic is_nan;
        is_nan = (y[14:10] == 5'h1F) && (y[9:0] != 10'h0);
        return (en && !is_nan && y[15]) ? FP16_ZERO : y;
    endfunction
endpackage

// File: rtl/conv_och_lane.sv
// One output channel: coefficient storage plus the S1..S5 multiply/add-tree datapath.
module conv_och_lane
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    input  logic              ld_out,
    input  logic              w_we,
    input  logic [3:0]        w_addr,
    input  fp16_t             w_data,
    input  fp16_t [NTAPS-1:0] ifmap,
    input  logic              relu_en,
    output fp16_t             ofmap
);
    fp16_t [NTAPS-1:0] w_q, w_d, prod;
    fp16_t             bias_q, bias_d, ofmap_q, ofmap_d;
    fp16_t [3:0]       s_sum;
    fp16_t             q0, q1, r, t, y;
    s1_t               s1_q, s1_d;
    s2_t               s2_q, s2_d;
    s3_t               s3_q, s3_d;
    s4_t               s4_q, s4_d;

    for (genvar i = 0; i < NTAPS; i++) begin : g_mul
        float_multi u_mul (.a(w_q[i]), .b(ifmap[i]), .y(prod[i]));
    end
    for (genvar i = 0; i < 4; i++) begin : g_s2
        float_add u_add (.a(s1_q.p[2*i]), .b(s1_q.p[2*i+1]), .y(s_sum[i]));
    end
    float_add u_q0 (.a(s2_q.s[0]), .b(s2_q.s[1]), .y(q0));
    float_add u_q1 (.a(s2_q.s[2]), .b(s2_q.s[3]), .y(q1));
    float_add u_r  (.a(s3_q.q0),   .b(s3_q.q1),   .y(r));
    float_add u_t  (.a(s3_q.p8),   .b(s3_q.bias), .y(t));
    float_add u_y  (.a(s4_q.r),    .b(s4_q.t),    .y(y));

    always_comb begin
        w_d    = w_q;
        bias_d = bias_q;
        for (int i = 0; i < NTAPS; i++)
            if (w_we && (w_addr == 4'(i))) w_d[i] = w_data;
        if (w_we && (w_addr == 4'(NTAPS))) bias_d = w_data;

        s1_d    = s1_q;
        s2_d    = s2_q;
        s3_d    = s3_q;
        s4_d    = s4_q;
        ofmap_d = ofmap_q;
        // Products use the pre-write coefficients, so a same-edge write hits the next beat.
        if (adv) begin
            s1_d = '{p: prod, bias: bias_q, relu: relu_en};
            s2_d = '{s: s_sum, p8: s1_q.p[NTAPS-1], bias: s1_q.bias, relu: s1_q.relu};
            s3_d = '{q0: q0, q1: q1, p8: s2_q.p8, bias: s2_q.bias, relu: s2_q.relu};
            s4_d = '{r: r, t: t, relu: s3_q.relu};
        end
        if (ld_out) ofmap_d = relu_act(y, s4_q.relu);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q     <= '0;
            bias_q  <= FP16_ZERO;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            s4_q    <= '0;
            ofmap_q <= FP16_ZERO;
        end else begin
            w_q     <= w_d;
            bias_q  <= bias_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            s4_q    <= s4_d;
            ofmap_q <= ofmap_d;
        end
    end

    assign ofmap = ofmap_q;
endmodule

// File: rtl/float_add.sv
// Combinational fp16 adder: RNE, subnormal inputs/results flushed to signed zero.
module float_add
    import conv_pkg::*;
(
    input  fp16_t a,
    input  fp16_t b,
    output fp16_t y
);
    fp16_t             big, sml;
    logic [42:0]       ma, mb, sum;
    logic [41:0]       norm;
    logic [5:0]        lead;
    logic signed [7:0] e;
    logic              nan_a, nan_b, inf_a, inf_b, rb;
    logic [14:0]       mag;

    always_comb begin
        big   = a;
        sml   = b;
        if (a[14:0] < b[14:0]) begin
            big = b;
            sml = a;
        end
        nan_a = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
        nan_b = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
        inf_a = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
        inf_b = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
        // 31 extra low bits make the alignment shift exact, so one rounding step suffices.
        ma    = {1'b0, 1'b1, big[9:0], 31'h0};
        mb    = {1'b0, 1'b1, sml[9:0], 31'h0} >> (big[14:10] - sml[14:10]);
        sum   = (big[15] == sml[15]) ? ma + mb : ma - mb;
        lead  = '0;
        for (int i = 0; i < 43; i++)
            if (sum[i]) lead = 6'(i);
        norm  = 42'(sum << (6'd42 - lead));
        rb    = norm[31] & ((|norm[30:0]) | norm[32]);
        e     = 8'(big[14:10]) + 8'(lead) - 8'd41;
        mag   = {e[4:0], norm[41:32]} + 15'(rb);

        if (nan_a || nan_b || (inf_a && inf_b && (a[15] != b[15])))
            y = FP16_QNAN;
        else if (inf_a)
            y = a;
        else if (inf_b)
            y = b;
        else if (sml[14:10] == 5'h0)
            y = (big[14:10] == 5'h0) ? {a[15] & b[15], 15'h0} : big;
        else if (sum == '0)
            y = FP16_ZERO;
        else if (e >= 8'sd31)
            y = {big[15], 5'h1F, 10'h0};
        else if (e <= 8'sd0)
            y = {big[15], 15'h0};
        else
            y = {big[15], mag};
    end
endmodule

// File: rtl/float_multi.sv
// Combinational fp16 multiplier: RNE, subnormal inputs/results flushed to signed zero.
module float_multi
    import conv_pkg::*;
(
    input  fp16_t a,
    input  fp16_t b,
    output fp16_t y
);
    logic              s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, rb;
    logic [21:0]       prod;
    logic [9:0]        mant;
    logic signed [7:0] e;
    logic [14:0]       mag;

    always_comb begin
        s      = a[15] ^ b[15];
        nan_a  = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
        nan_b  = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
        inf_a  = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
        inf_b  = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
        zero_a = (a[14:10] == 5'h0);
        zero_b = (b[14:10] == 5'h0);
        prod   = {1'b1, a[9:0]} * {1'b1, b[9:0]};
        // Product of two 1.x mantissas lies in [1,4): bit 21 picks the normalisation.
        if (prod[21]) begin
            mant = prod[20:11];
            rb   = prod[10] & ((|prod[9:0]) | prod[11]);
        end else begin
            mant = prod[19:10];
            rb   = prod[9] & ((|prod[8:0]) | prod[10]);
        end
        e   = 8'(a[14:10]) + 8'(b[14:10]) - 8'd15 + 8'(prod[21]);
        mag = {e[4:0], mant} + 15'(rb);

        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a))
            y = FP16_QNAN;
        else if (inf_a || inf_b)
            y = {s, 5'h1F, 10'h0};
        else if (zero_a || zero_b)
            y = {s, 15'h0};
        else if (e >= 8'sd31)
            y = {s, 5'h1F, 10'h0};
        else if (e <= 8'sd0)
            y = {s, 15'h0};
        else
            y = {s, mag};
    end
endmodule

// File: rtl/conv_kernel_mc.sv
// Multi-channel 3x3 fp16 convolution kernel: shared valid pipeline, one lane per output channel.
module conv_kernel_mc
    import conv_pkg::*;
#(
    parameter int   NUM_OCH      = 2,
    parameter logic RELU_DEFAULT = 1'b0,
    localparam int  OCH_W        = (NUM_OCH > 1) ? $clog2(NUM_OCH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NTAPS-1:0][15:0]    ifmap_3x3,
    input  logic                      w_we,
    input  logic [OCH_W-1:0]          w_och,
    input  logic [3:0]                w_addr,
    input  logic [15:0]               w_data,
    input  logic                      cfg_relu_we,
    input  logic                      cfg_relu,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_OCH-1:0][15:0]  ofmap,
    output logic                      idle
);
    logic [CONV_LAT-1:0] vld_pipe_q, vld_pipe_d;
    logic                relu_q, relu_d;
    logic                stall, accept, adv, ld_out;

    always_comb begin
        stall      = vld_pipe_q[CONV_LAT-1] && !out_ready;
        accept     = in_valid && !stall;
        adv        = !stall;
        ld_out     = adv && vld_pipe_q[CONV_LAT-2];
        vld_pipe_d = stall ? vld_pipe_q : {vld_pipe_q[CONV_LAT-2:0], accept};
        relu_d     = cfg_relu_we ? cfg_relu : relu_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            relu_q     <= RELU_DEFAULT;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            relu_q     <= relu_d;
        end
    end

    assign in_ready  = !stall;
    assign out_valid = vld_pipe_q[CONV_LAT-1];
    assign idle      = ~|vld_pipe_q;

    // Out-of-range w_och matches no lane; out-of-range w_addr is dropped inside the lane.
    for (genvar c = 0; c < NUM_OCH; c++) begin : g_lane
        conv_och_lane u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .adv     (adv),
            .ld_out  (ld_out),
            .w_we    (w_we && (w_och == OCH_W'(c))),
            .w_addr  (w_addr),
            .w_data  (w_data),
            .ifmap   (ifmap_3x3),
            .relu_en (relu_q),
            .ofmap   (ofmap[c])
        );
    end
endmodule

// File: tb/tb_conv_kernel_mc.sv
// Directed bench for conv_kernel_mc: vector table plus stall, same-edge write and reset sequences.
module tb_conv_kernel_mc;
    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [8:0][15:0] ifmap_3x3 = '0;
    logic             w_we = 1'b0;
    logic [0:0]       w_och = '0;
    logic [3:0]       w_addr = '0;
    logic [15:0]      w_data = '0;
    logic             cfg_relu_we = 1'b0;
    logic             cfg_relu = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [1:0][15:0] ofmap;
    logic             idle;

    int n_vec = 0;
    int n_err = 0;

    conv_kernel_mc #(.NUM_OCH(2), .RELU_DEFAULT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ifmap_3x3(ifmap_3x3), .w_we(w_we), .w_och(w_och), .w_addr(w_addr),
        .w_data(w_data), .cfg_relu_we(cfg_relu_we), .cfg_relu(cfg_relu),
        .out_valid(out_valid), .out_ready(out_ready), .ofmap(ofmap), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x, w0, b0, w1, b1;
        logic        relu;
        logic [15:0] e0, e1;
    } vec_t;
    vec_t tbl[8];

    logic [15:0] sx[8];
    logic [15:0] se[8];
    int beat, got, cyc, lat;
    bit seen;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input int och, input int addr, input logic [15:0] d);
        w_we = 1'b1; w_och = 1'(och); w_addr = 4'(addr); w_data = d;
        step();
        w_we = 1'b0;
    endtask

    task automatic load(input logic [15:0] w0, b0, w1, b1);
        for (int i = 0; i < 9; i++) begin
            wr(0, i, w0);
            wr(1, i, w1);
        end
        wr(0, 9, b0);
        wr(1, 9, b1);
        wr(0, 10, 16'h7E00);
        wr(1, 15, 16'h7E00);
    endtask

    task automatic set_relu(input logic v);
        cfg_relu_we = 1'b1; cfg_relu = v;
        step();
        cfg_relu_we = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
    endtask

    // Two back-to-back beats of ones; optional strobe lands on the first beat's accepting edge.
    task automatic two_beats(input string name, input bit do_w, input bit do_cfg,
                             input logic [15:0] ea, eb, e1);
        int n;
        ifmap_3x3 = {9{16'h3C00}};
        in_valid = 1'b1;
        if (do_w) begin
            w_we = 1'b1; w_och = 1'b0; w_addr = 4'd0; w_data = 16'h4000;
        end
        if (do_cfg) begin
            cfg_relu_we = 1'b1; cfg_relu = 1'b1;
        end
        step();
        w_we = 1'b0; cfg_relu_we = 1'b0;
        step();
        in_valid = 1'b0;
        wait_out(n);
        check({name, "_first"}, ofmap[0], ea);
        check({name, "_first_ch1"}, ofmap[1], e1);
        step();
        check({name, "_second_valid"}, 16'(out_valid), 16'h1);
        check({name, "_second"}, ofmap[0], eb);
        step();
    endtask

    initial begin
        tbl[0] = '{16'h3C00, 16'h3C00, 16'h0000, 16'h4000, 16'h3800, 1'b0, 16'h4880, 16'h4CA0};
        tbl[1] = '{16'h3C00, 16'h3C00, 16'h3800, 16'h4000, 16'h3800, 1'b0, 16'h48C0, 16'h4CA0};
        tbl[2] = '{16'h3C00, 16'hBC00, 16'h0000, 16'h4000, 16'h0000, 1'b1, 16'h0000, 16'h4C80};
        tbl[3] = '{16'h3C00, 16'hBC00, 16'h0000, 16'hC000, 16'h3800, 1'b0, 16'hC880, 16'hCC60};
        tbl[4] = '{16'h4000, 16'h3C00, 16'h0000, 16'h3800, 16'hBC00, 1'b0, 16'h4C80, 16'h4800};
        tbl[5] = '{16'h3C00, 16'h0000, 16'h0000, 16'h3C00, 16'hC880, 1'b0, 16'h0000, 16'h0000};
        tbl[6] = '{16'h3C00, 16'h7E00, 16'h0000, 16'hBC00, 16'h0000, 1'b1, 16'h7E00, 16'h0000};
        tbl[7] = '{16'h0001, 16'h3C00, 16'h3C00, 16'h7BFF, 16'h0000, 1'b0, 16'h3C00, 16'h0000};
        sx = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800};
        se = '{16'h4880, 16'h4C80, 16'h4EC0, 16'h5080, 16'h51A0, 16'h52C0, 16'h53E0, 16'h5480};

        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 16'(out_valid), 16'h0);
        check("rst_idle", 16'(idle), 16'h1);
        check("rst_ofmap0", ofmap[0], 16'h0000);
        check("rst_ofmap1", ofmap[1], 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 16'(in_ready), 16'h1);

        for (int i = 0; i < 8; i++) begin
            load(tbl[i].w0, tbl[i].b0, tbl[i].w1, tbl[i].b1);
            set_relu(tbl[i].relu);
            ifmap_3x3 = {9{tbl[i].x}};
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            wait_out(lat);
            check($sformatf("latency[%0d]", i), 16'(lat + 1), 16'd5);
            check($sformatf("och0[%0d]", i), ofmap[0], tbl[i].e0);
            check($sformatf("och1[%0d]", i), ofmap[1], tbl[i].e1);
            step();
            check($sformatf("bubble[%0d]", i), 16'(out_valid), 16'h0);
        end

        // Stream of 8 beats with out_ready low in cycles 7..9.
        load(16'h3C00, 16'h0000, 16'h3C00, 16'h0000);
        set_relu(1'b0);
        beat = 0; got = 0; cyc = 0;
        while (got < 8 && cyc < 60) begin
            out_ready = !(cyc >= 7 && cyc <= 9);
            in_valid  = (beat < 8);
            ifmap_3x3 = {9{sx[(beat < 8) ? beat : 7]}};
            #1;
            if (out_valid) begin
                check($sformatf("stream_och0[%0d]", got), ofmap[0], se[got]);
                check($sformatf("stream_och1[%0d]", got), ofmap[1], se[got]);
            end
            if (!out_ready) check("stall_in_ready", 16'(in_ready), 16'h0);
            if (out_valid && out_ready) got++;
            if (in_valid && in_ready) beat++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 16'(got), 16'd8);

        // Same-edge coefficient write and relu write.
        load(16'h3C00, 16'h0000, 16'h3C00, 16'h0000);
        two_beats("w_same_edge", 1'b1, 1'b0, 16'h4880, 16'h4900, 16'h4880);
        load(16'hBC00, 16'h0000, 16'h3C00, 16'h0000);
        set_relu(1'b0);
        two_beats("relu_same_edge", 1'b0, 1'b1, 16'hC880, 16'h0000, 16'h4880);

        // Reset with three beats in flight.
        load(16'h3C00, 16'h0000, 16'h3C00, 16'h0000);
        ifmap_3x3 = {9{16'h3C00}};
        in_valid = 1'b1;
        step(); step(); step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 16'(out_valid), 16'h0);
        check("midrst_idle", 16'(idle), 16'h1);
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        check("postrst_no_valid", 16'(seen), 16'h0);
        check("postrst_idle", 16'(idle), 16'h1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(lat);
        check("postrst_latency", 16'(lat + 1), 16'd5);
        check("postrst_och0", ofmap[0], 16'h0000);
        check("postrst_och1", ofmap[1], 16'h0000);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
